// File: rtl/mega99_pkg.sv
// Shared mega99 definitions for the XMEM path.
// Holds bus widths and the arbiter state encoding.
package mega99_pkg;

    localparam int XMEM_AW = 30;
    localparam int XMEM_DW = 32;
    localparam int XMEM_SW = 4;

    typedef enum logic [1:0] {
        XS_IDLE  = 2'd0,
        XS_OWN0  = 2'd1,
        XS_OWN1  = 2'd2,
        XS_ABORT = 2'd3
    } xmem_state_e;

endpackage

// File: rtl/xmem_arbiter.sv
// Two-master Wishbone arbiter in front of the HyperRAM wrapper.
// Alternating tie-break, no preemption, stall watchdog with abort.
module xmem_arbiter
    import mega99_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [2:XMEM_AW+1]    m0_adr_i,
    input  logic [0:XMEM_DW-1]    m0_dat_i,
    output logic [0:XMEM_DW-1]    m0_dat_o,
    input  logic                  m0_we_i,
    input  logic [0:XMEM_SW-1]    m0_sel_i,
    input  logic                  m0_stb_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m0_cyc_i,

    input  logic [2:XMEM_AW+1]    m1_adr_i,
    input  logic [0:XMEM_DW-1]    m1_dat_i,
    output logic [0:XMEM_DW-1]    m1_dat_o,
    input  logic                  m1_we_i,
    input  logic [0:XMEM_SW-1]    m1_sel_i,
    input  logic                  m1_stb_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    input  logic                  m1_cyc_i,

    output logic [2:XMEM_AW+1]    s_adr_o,
    output logic [0:XMEM_DW-1]    s_dat_o,
    input  logic [0:XMEM_DW-1]    s_dat_i,
    output logic                  s_we_o,
    output logic [0:XMEM_SW-1]    s_sel_o,
    output logic                  s_stb_o,
    input  logic                  s_ack_i,
    output logic                  s_cyc_o,

    output logic [1:0]            grant
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    xmem_state_e state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        own_stb;
    logic        stalled;

    assign own_stb = ((state_q == XS_OWN0) && m0_stb_i) ||
                     ((state_q == XS_OWN1) && m1_stb_i);
    assign stalled = own_stb && !s_ack_i;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // Read data fans out to both masters; only ack is steered.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // State, last owner and stall counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= XS_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ownership arbitration, handover and stall watchdog
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = 16'd0;
        case (state_q)
            XS_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = XS_OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = XS_OWN1;
                    last_d  = 1'b1;
                end
            end
            XS_OWN0: begin
                if (!m0_cyc_i) begin
                    if (m1_cyc_i) begin
                        state_d = XS_OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = XS_IDLE;
                    end
                end else if (stalled) begin
                    if (cnt_inc >= TO_LIM) begin
                        state_d = XS_ABORT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            XS_OWN1: begin
                if (!m1_cyc_i) begin
                    if (m0_cyc_i) begin
                        state_d = XS_OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = XS_IDLE;
                    end
                end else if (stalled) begin
                    if (cnt_inc >= TO_LIM) begin
                        state_d = XS_ABORT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            XS_ABORT: begin
                state_d = XS_IDLE;
            end
            default: begin
                state_d = XS_IDLE;
            end
        endcase
    end

    // Slave-side mux and master-side ack/err steering
    always_comb begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        grant    = 2'b00;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            XS_OWN0: begin
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                grant    = 2'b01;
                m0_ack_o = m0_stb_i && s_ack_i;
            end
            XS_OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                grant    = 2'b10;
                m1_ack_o = m1_stb_i && s_ack_i;
            end
            XS_ABORT: begin
                m0_err_o = !last_q;
                m1_err_o = last_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/xmem_arbiter.md
XMEM_ARBITER -- requirements
Module: xmem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: stalled-strobe cycle count before a forced error termination (range 2..65535).
REQ-002 SHALL have port clk, input, 1: single clock for all logic (system clock, 108 MHz in the R6 build).
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports m0_adr_i [2:31], m0_dat_i [0:31], m0_dat_o [0:31], m0_we_i, m0_sel_i [0:3], m0_stb_i, m0_ack_o, m0_err_o, m0_cyc_i: Wishbone master 0 (service processor), big-endian bit numbering.
REQ-005 SHALL have the identical port set m1_*: Wishbone master 1 (secondary requester, e.g. DMA).
REQ-006 SHALL have ports s_adr_o [2:31], s_dat_o [0:31], s_dat_i [0:31], s_we_o, s_sel_o [0:3], s_stb_o, s_ack_i, s_cyc_o: shared slave port to the HyperRAM wrapper.
REQ-007 SHALL have port grant, output, 2: one-hot current owner {m1,m0}, 00 when idle.

Function
REQ-008 SHALL implement a registered FSM with states IDLE, OWN0, OWN1, ABORT.
REQ-009 In IDLE, SHALL go to OWN0 or OWN1 when the corresponding cyc_i is high; if both are high, SHALL pick the master not granted last (last_owner reset value = 1, so m0 wins the first tie).
REQ-010 SHALL take exactly one cycle from request to ownership: cyc_i seen high in IDLE at edge n -> slave signals driven from that master from cycle n+1.
REQ-011 In OWNx, SHALL route adr/dat/we/sel/stb/cyc of master x combinationally to s_*; the non-owner sees ack_o=0 and err_o=0.
REQ-012 SHALL route s_dat_i to both m0_dat_o and m1_dat_o; s_ack_i goes only to the owner's ack_o, gated by owner stb_i.
REQ-013 SHALL hold ownership for as long as the owner's cyc_i stays high, including multi-strobe bursts and read-modify-write sequences; no preemption.
REQ-014 When the owner drops cyc_i, SHALL go to the other OWN state if the other cyc_i is high, else IDLE; the slave sees cyc_o=0 for at least that one cycle between owners.
REQ-015 SHALL update last_owner on every IDLE->OWNx or OWNx->OWNy transition.
REQ-016 SHALL count cycles with the owner's stb_i high and s_ack_i low, 16-bit saturating, cleared on ack or stb low.
REQ-017 When the count reaches TIMEOUT_CYCLES, SHALL enter ABORT: s_cyc_o=0 and s_stb_o=0 for one cycle, owner err_o=1 for that cycle, then IDLE.
REQ-018 An s_ack_i arriving in ABORT SHALL be discarded and not forwarded.
REQ-019 A cyc_i that drops during ABORT SHALL not alter the ABORT->IDLE transition.
REQ-020 In IDLE and ABORT, SHALL drive s_cyc_o=0, s_stb_o=0, s_we_o=0, and s_sel_o/s_adr_o/s_dat_o to master 0's values (don't-care to the slave).

Reset
REQ-021 With reset_n low at a clk edge, SHALL go to IDLE, set last_owner=1, clear the timeout counter, and drive grant=00, s_cyc_o=0, s_stb_o=0, both ack_o and err_o 0 from the next cycle.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err issued; masters restart after reset.

Structure
REQ-023 SHALL place the state encoding (IDLE=0, OWN0=1, OWN1=2, ABORT=3) and the XMEM address/data/sel widths (30/32/4) in the shared mega99 package; no sub-module, single flat module of roughly 150-250 lines.
REQ-024 SHALL be instantiated between the sp xmem port and hyperram_wrapper, with the sp on m0.

Verification
REQ-025 Single read: m0 cyc/stb at adr 0x0000100, slave acks after 5 cycles with data 0xDEADBEEF -> grant=01 one cycle after request, m0_ack_o on the slave-ack cycle with m0_dat_o=0xDEADBEEF, m1_ack_o=0.
REQ-026 Simultaneous request after reset: m0 and m1 cyc rise on the same edge -> m0 owns first; when m0 drops cyc, grant goes 01->10 with exactly one cycle of s_cyc_o=0.
REQ-027 Round-robin fairness: both masters continuously issue 4-word bursts (cyc held across 4 stbs) -> grants alternate 01,10,01,10; no burst is split.
REQ-028 Timeout: TIMEOUT_CYCLES=8, m1 strobes, slave never acks -> 8 stalled cycles, then one ABORT cycle with m1_err_o=1 and s_cyc_o=0, then IDLE; an m0 request pending is granted next.
REQ-029 Reset mid-burst: reset_n low on the 2nd of 4 beats -> grant=00, s_cyc_o=0 the next cycle; no ack or err to either master; a late slave ack is not forwarded.
REQ-030 Late ack in ABORT: slave asserts s_ack_i in the ABORT cycle -> m*_ack_o stays 0.
